// File: rtl/raster_line_scheduler_if.sv
// Command, rasterizer and framebuffer-swap signal bundle for raster_line_scheduler.
// The slave modport is the scheduler itself; the master modport is its environment.
interface raster_line_scheduler_if #(
  parameter int DEPTH = 16,
  parameter int CW    = 13,
  parameter int COLW  = 4
);
  logic                      cmdValid;
  logic                      cmdReady;
  logic                      cmdFrameEnd;
  logic signed [CW-1:0]      cmdStartX, cmdEndX, cmdStartY, cmdEndY;
  logic [COLW-1:0]           cmdColor;
  logic                      flush;
  logic                      rastReady;
  logic                      rastDone;
  logic                      rastGo;
  logic signed [CW-1:0]      rastStartX, rastEndX, rastStartY, rastEndY;
  logic [COLW-1:0]           rastColor;
  logic                      swapReq;
  logic                      swapAck;
  logic [$clog2(DEPTH):0]    level;
  logic [15:0]               lineCount;
  logic [7:0]                frameCount;
  logic                      busy;

  modport slave (
    input  cmdValid, cmdFrameEnd, cmdStartX, cmdEndX, cmdStartY, cmdEndY, cmdColor,
           flush, rastReady, rastDone, swapAck,
    output cmdReady, rastGo, rastStartX, rastEndX, rastStartY, rastEndY, rastColor,
           swapReq, level, lineCount, frameCount, busy
  );

  modport master (
    output cmdValid, cmdFrameEnd, cmdStartX, cmdEndX, cmdStartY, cmdEndY, cmdColor,
           flush, rastReady, rastDone, swapAck,
    input  cmdReady, rastGo, rastStartX, rastEndX, rastStartY, rastEndY, rastColor,
           swapReq, level, lineCount, frameCount, busy
  );
endinterface

// File: rtl/raster_line_scheduler.sv
// Line-command FIFO feeding the Bresenham rasterizer one segment at a time, with
// end-of-frame markers turned into a framebuffer swap once all earlier lines are drawn.
module raster_line_scheduler #(
  parameter int DEPTH = 16,
  parameter int CW    = 13,
  parameter int COLW  = 4
) (
  input logic                    clk,
  input logic                    rst,
  raster_line_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic                 fe;
    logic signed [CW-1:0] sx, ex, sy, ey;
    logic [COLW-1:0]      col;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SWAP} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  cmd_t          head, wdat;
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] lvl;
  logic          push, pop, latch, empty;
  logic [15:0]   lines;
  logic [7:0]    frames;

  assign empty = (lvl == '0);
  assign head  = mem[rp];
  assign wdat  = {bus.cmdFrameEnd, bus.cmdStartX, bus.cmdEndX, bus.cmdStartY, bus.cmdEndY,
                  bus.cmdColor};

  assign bus.cmdReady   = (lvl != LW'(DEPTH));
  assign push           = bus.cmdValid && bus.cmdReady && !bus.flush;
  assign bus.rastGo     = (state == S_ISSUE);
  assign bus.swapReq    = (state == S_SWAP);
  assign bus.level      = lvl;
  assign bus.lineCount  = lines;
  assign bus.frameCount = frames;
  assign bus.busy       = (state != S_IDLE) || !empty;

  // Only IDLE pops; a flush in the same cycle freezes the head so nothing stale issues.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    latch     = 1'b0;
    case (state)
      S_IDLE: if (!bus.flush && !empty) begin
        if (head.fe) begin
          pop       = 1'b1;
          state_nxt = S_SWAP;
        end else if (bus.rastReady) begin
          pop       = 1'b1;
          latch     = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: if (bus.rastReady) state_nxt = S_WAIT;
      S_WAIT:  if (bus.rastDone)  state_nxt = S_IDLE;
      S_SWAP:  if (bus.swapAck)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else if (bus.flush) begin
      rp  <= wp;
      lvl <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      lvl <= lvl + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdat;
  end

  // Operands stay put from the latch until the next line is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rastStartX <= '0;
      bus.rastEndX   <= '0;
      bus.rastStartY <= '0;
      bus.rastEndY   <= '0;
      bus.rastColor  <= '0;
    end else if (latch) begin
      bus.rastStartX <= head.sx;
      bus.rastEndX   <= head.ex;
      bus.rastStartY <= head.sy;
      bus.rastEndY   <= head.ey;
      bus.rastColor  <= head.col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lines  <= '0;
      frames <= '0;
    end else if (state == S_WAIT && bus.rastDone) begin
      if (lines != 16'hFFFF) lines <= lines + 16'd1;
    end else if (state == S_SWAP && bus.swapAck) begin
      lines  <= '0;
      frames <= frames + 8'd1;
    end
  end
endmodule

// File: tb/tb_raster_line_scheduler.sv
// Directed scenarios plus random traffic against a queue-based reference of the scheduler.
module tb_raster_line_scheduler;
  localparam int DEPTH = 16;
  localparam int CW    = 13;
  localparam int COLW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  raster_line_scheduler_if #(.DEPTH(DEPTH), .CW(CW), .COLW(COLW)) bus();
  raster_line_scheduler #(.DEPTH(DEPTH), .CW(CW), .COLW(COLW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic                 fe;
    logic signed [CW-1:0] sx, ex, sy, ey;
    logic [COLW-1:0]      col;
  } cmd_t;

  // Reference: pending commands, the line handed over, and what the rasterizer/swap side owes.
  cmd_t q[$];
  cmd_t m_lat;
  bit   m_go, m_draw, m_swap;
  int   m_lines, m_frames;

  int total = 0, bad = 0;
  int gos = 0, xfers = 0;
  bit auto_rd = 0;
  int rd_delay = 1, rd_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_lat = '0;
    m_go = 0; m_draw = 0; m_swap = 0;
    m_lines = 0; m_frames = 0;
    rd_cnt = 0;
  endtask

  task automatic mstep();
    cmd_t c;
    bit   room;
    room = q.size() < DEPTH;
    c = {bus.cmdFrameEnd, bus.cmdStartX, bus.cmdEndX, bus.cmdStartY, bus.cmdEndY, bus.cmdColor};
    if (m_go) begin
      if (bus.rastReady) begin m_go = 0; m_draw = 1; end
    end else if (m_draw) begin
      if (bus.rastDone) begin m_draw = 0; if (m_lines < 65535) m_lines++; end
    end else if (m_swap) begin
      if (bus.swapAck) begin m_swap = 0; m_frames = (m_frames + 1) % 256; m_lines = 0; end
    end else if (!bus.flush && q.size() > 0) begin
      if (q[0].fe) begin
        void'(q.pop_front());
        m_swap = 1;
      end else if (bus.rastReady) begin
        m_lat = q.pop_front();
        m_go  = 1;
      end
    end
    if (bus.flush) q.delete();
    else if (bus.cmdValid && room) q.push_back(c);
  endtask

  task automatic check();
    chk("rastGo",     64'(bus.rastGo),     64'(m_go));
    chk("swapReq",    64'(bus.swapReq),    64'(m_swap));
    chk("level",      64'(bus.level),      64'(q.size()));
    chk("cmdReady",   64'(bus.cmdReady),   64'(q.size() < DEPTH));
    chk("busy",       64'(bus.busy),       64'(m_go || m_draw || m_swap || q.size() != 0));
    chk("lineCount",  64'(bus.lineCount),  64'(m_lines));
    chk("frameCount", 64'(bus.frameCount), 64'(m_frames));
    chk("operands",
        64'({bus.rastStartX, bus.rastEndX, bus.rastStartY, bus.rastEndY, bus.rastColor}),
        64'({m_lat.sx, m_lat.ex, m_lat.sy, m_lat.ey, m_lat.col}));
    if (bus.rastGo) gos++;
    if (bus.rastGo && bus.rastReady) xfers++;
  endtask

  // One clock: check at negedge, advance the reference at posedge, optionally emulate rastDone.
  task automatic tick();
    bit xf;
    if (rst) mreset();
    @(negedge clk);
    check();
    xf = bus.rastGo && bus.rastReady;
    @(posedge clk);
    if (rst) mreset(); else mstep();
    #1;
    if (auto_rd) begin
      bus.rastDone = 1'b0;
      if (xf) rd_cnt = rd_delay;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) bus.rastDone = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put(input bit fe, input int sx, input int sy, input int ex, input int ey,
                     input int col);
    bus.cmdValid    = 1'b1;
    bus.cmdFrameEnd = fe;
    bus.cmdStartX   = CW'(sx);
    bus.cmdStartY   = CW'(sy);
    bus.cmdEndX     = CW'(ex);
    bus.cmdEndY     = CW'(ey);
    bus.cmdColor    = COLW'(col);
    tick();
    bus.cmdValid    = 1'b0;
    bus.cmdFrameEnd = 1'b0;
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic put_rand();
    put(1'b0, rnd(), rnd(), rnd(), rnd(), int'($urandom_range(0, 15)));
  endtask

  int g0, x0, lc0;

  initial begin
    bus.cmdValid = 0; bus.cmdFrameEnd = 0; bus.cmdColor = '0;
    bus.cmdStartX = '0; bus.cmdEndX = '0; bus.cmdStartY = '0; bus.cmdEndY = '0;
    bus.flush = 0; bus.rastReady = 0; bus.rastDone = 0; bus.swapAck = 0;
    mreset();
    run(2);
    chk("rst_level", 64'(bus.level), 64'(0));
    chk("rst_ready", 64'(bus.cmdReady), 64'(1));
    chk("rst_ops", 64'({bus.rastStartX, bus.rastEndY, bus.rastColor}), 64'(0));
    rst = 1'b0;
    run(2);

    // single line, done 10 cycles after transfer
    auto_rd = 1; rd_delay = 10; bus.rastReady = 1;
    put(1'b0, -25, 50, 75, 250, 5);
    tick();
    chk("t1_go_on", 64'(bus.rastGo), 64'(1));
    tick();
    chk("t1_go_off", 64'(bus.rastGo), 64'(0));
    chk("t1_sx", 64'(bus.rastStartX), 64'(-25));
    chk("t1_ey", 64'(bus.rastEndY), 64'(250));
    chk("t1_col", 64'(bus.rastColor), 64'(5));
    run(14);
    chk("t1_lines", 64'(bus.lineCount), 64'(1));
    chk("t1_busy", 64'(bus.busy), 64'(0));

    // three lines then a frame end, swap held off
    for (int i = 0; i < 3; i++) put_rand();
    put(1'b1, 0, 0, 0, 0, 0);
    run(60);
    chk("t2_swapreq", 64'(bus.swapReq), 64'(1));
    chk("t2_lines", 64'(bus.lineCount), 64'(4));
    bus.swapAck = 1; tick(); bus.swapAck = 0; tick();
    chk("t2_swapdone", 64'(bus.swapReq), 64'(0));
    chk("t2_frames", 64'(bus.frameCount), 64'(1));
    chk("t2_lines0", 64'(bus.lineCount), 64'(0));

    // fill past capacity, then drain in order
    rd_delay = 1; bus.rastReady = 0;
    for (int i = 0; i < DEPTH + 2; i++) put_rand();
    chk("t3_full", 64'(bus.level), 64'(DEPTH));
    chk("t3_noready", 64'(bus.cmdReady), 64'(0));
    x0 = xfers;
    bus.rastReady = 1;
    run(120);
    chk("t3_xfers", 64'(xfers - x0), 64'(DEPTH));
    chk("t3_empty", 64'(bus.level), 64'(0));

    // rasterizer stalls during ISSUE
    put_rand();
    tick();
    g0 = gos; x0 = xfers;
    bus.rastReady = 0;
    run(4);
    bus.rastReady = 1;
    run(10);
    chk("t4_gos", 64'(gos - g0), 64'(5));
    chk("t4_xfers", 64'(xfers - x0), 64'(1));

    // flush with a line in flight
    auto_rd = 0;
    for (int i = 0; i < 6; i++) put_rand();
    chk("t5_level", 64'(bus.level), 64'(5));
    bus.flush = 1; tick(); bus.flush = 0;
    chk("t5_flushed", 64'(bus.level), 64'(0));
    lc0 = m_lines;
    tick();
    bus.rastDone = 1; tick(); bus.rastDone = 0; tick();
    chk("t5_lines", 64'(bus.lineCount), 64'(lc0 + 1));
    g0 = gos;
    run(10);
    chk("t5_nogo", 64'(gos - g0), 64'(0));

    // async reset mid-line
    put_rand();
    run(2);
    rst = 1'b1;
    #1;
    chk("t6_go", 64'(bus.rastGo), 64'(0));
    chk("t6_busy", 64'(bus.busy), 64'(0));
    chk("t6_frames", 64'(bus.frameCount), 64'(0));
    chk("t6_ready", 64'(bus.cmdReady), 64'(1));
    run(2);
    rst = 1'b0;
    tick();
    auto_rd = 1;
    put_rand();
    run(10);
    chk("t6_lines", 64'(bus.lineCount), 64'(1));

    // random traffic
    auto_rd = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.cmdValid    = 1'($urandom_range(0, 1));
      bus.cmdFrameEnd = ($urandom_range(0, 7) == 0);
      bus.cmdStartX   = CW'(rnd());
      bus.cmdEndX     = CW'(rnd());
      bus.cmdStartY   = CW'(rnd());
      bus.cmdEndY     = CW'(rnd());
      bus.cmdColor    = COLW'($urandom_range(0, 15));
      bus.flush       = ($urandom_range(0, 49) == 0);
      bus.rastReady   = ($urandom_range(0, 3) != 0);
      bus.rastDone    = ($urandom_range(0, 4) == 0);
      bus.swapAck     = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
